// File: rtl/csr_regfile_if.sv
`default_nettype none
// ============================================================================
//  Module      : csr_regfile_if
//  Description : Writeback-stage CSR/exception bus between the pipeline
//                (master) and the CSR register file (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface csr_regfile_if;
  logic [13:0] csr_rnum;
  logic [31:0] csr_rvalue;
  logic        csr_we;
  logic [13:0] csr_num;
  logic [31:0] csr_wmask;
  logic [31:0] csr_wdata;
  logic        wb_ex;
  logic [5:0]  wb_ecode;
  logic [8:0]  wb_esubcode;
  logic [31:0] wb_pc;
  logic [31:0] wb_vaddr;
  logic        ertn_flush;
  logic [7:0]  hw_int_in;
  logic        ipi_int_in;
  logic        has_int;
  logic [31:0] ex_entry;
  logic [31:0] era_pc;
  logic [31:0] tid_rvalue;

  modport master (
    output csr_rnum, csr_we, csr_num, csr_wmask, csr_wdata,
           wb_ex, wb_ecode, wb_esubcode, wb_pc, wb_vaddr, ertn_flush,
           hw_int_in, ipi_int_in,
    input  csr_rvalue, has_int, ex_entry, era_pc, tid_rvalue
  );

  modport slave (
    input  csr_rnum, csr_we, csr_num, csr_wmask, csr_wdata,
           wb_ex, wb_ecode, wb_esubcode, wb_pc, wb_vaddr, ertn_flush,
           hw_int_in, ipi_int_in,
    output csr_rvalue, has_int, ex_entry, era_pc, tid_rvalue
  );
endinterface
`default_nettype wire

// File: rtl/csr_regfile.sv
`default_nettype none
// ============================================================================
//  Module      : csr_regfile
//  Description : Control/status register file. Combinational CSR reads,
//                masked CSR writes, exception entry and ertn return from WB,
//                interrupt request generation.
//                Define CSR_TIMER_EN to build TCFG/TVAL/TICLR and the timer
//                interrupt (ESTAT.IS[11]).
//  Revision    : 1.0 - initial release
// ============================================================================
module csr_regfile #(
  parameter int          TIMER_W  = 32,
  parameter logic [31:0] TID_INIT = 32'h0
) (
  input wire           clk,
  input wire           resetn,
  csr_regfile_if.slave bus
);

  localparam logic [13:0] c_ADDR_CRMD   = 14'h000;
  localparam logic [13:0] c_ADDR_PRMD   = 14'h001;
  localparam logic [13:0] c_ADDR_ECFG   = 14'h004;
  localparam logic [13:0] c_ADDR_ESTAT  = 14'h005;
  localparam logic [13:0] c_ADDR_ERA    = 14'h006;
  localparam logic [13:0] c_ADDR_BADV   = 14'h007;
  localparam logic [13:0] c_ADDR_EENTRY = 14'h00C;
  localparam logic [11:0] c_ADDR_SAVE_HI = 12'h00C;  // 0x30..0x33 >> 2
  localparam logic [13:0] c_ADDR_TID    = 14'h040;
  localparam logic [13:0] c_ADDR_TCFG   = 14'h041;
  localparam logic [13:0] c_ADDR_TVAL   = 14'h042;
  localparam logic [5:0]  c_ECODE_ADE   = 6'h08;
  localparam logic [5:0]  c_ECODE_ALE   = 6'h09;
  localparam logic [8:0]  c_ESUB_ADEF   = 9'h000;
  localparam logic [3:0]  c_CRMD_RST    = 4'h8;
  localparam logic [12:0] c_LIE_MASK    = 13'h1BFF;  // bit 10 has no source

  logic [3:0]  r_crmd;       // {DA, IE, PLV[1:0]}
  logic [2:0]  r_prmd;       // {PIE, PPLV[1:0]}
  logic [12:0] r_ecfg;       // LIE
  logic [1:0]  r_is_sw;
  logic [7:0]  r_is_hw;
  logic        r_is_ipi;
  logic [5:0]  r_ecode;
  logic [8:0]  r_esubcode;
  logic [31:0] r_era;
  logic [31:0] r_badv;
  logic [25:0] r_eentry;
  logic [31:0] r_save [4];
  logic [31:0] r_tid;

  logic [TIMER_W-1:0] w_tcfg_v;
  logic [TIMER_W-1:0] w_tval_v;
  logic               w_ti_v;
  logic [12:0]        w_is;
  logic [31:0]        w_estat;
  logic [31:0]        w_rvalue;

  wire [31:0] w_m = bus.csr_wmask;
  wire [31:0] w_d = bus.csr_wdata;

  wire w_we_crmd   = bus.csr_we && (bus.csr_num == c_ADDR_CRMD);
  wire w_we_prmd   = bus.csr_we && (bus.csr_num == c_ADDR_PRMD);
  wire w_we_ecfg   = bus.csr_we && (bus.csr_num == c_ADDR_ECFG);
  wire w_we_estat  = bus.csr_we && (bus.csr_num == c_ADDR_ESTAT);
  wire w_we_era    = bus.csr_we && (bus.csr_num == c_ADDR_ERA);
  wire w_we_badv   = bus.csr_we && (bus.csr_num == c_ADDR_BADV);
  wire w_we_eentry = bus.csr_we && (bus.csr_num == c_ADDR_EENTRY);
  wire w_we_save   = bus.csr_we && (bus.csr_num[13:2] == c_ADDR_SAVE_HI);
  wire w_we_tid    = bus.csr_we && (bus.csr_num == c_ADDR_TID);

  wire [3:0]  w_crmd_new = (r_crmd & ~w_m[3:0]) | (w_d[3:0] & w_m[3:0]);
  wire [2:0]  w_prmd_new = (r_prmd & ~w_m[2:0]) | (w_d[2:0] & w_m[2:0]);
  wire [12:0] w_ecfg_new = ((r_ecfg & ~w_m[12:0]) | (w_d[12:0] & w_m[12:0])) & c_LIE_MASK;
  wire [1:0]  w_sw_new   = (r_is_sw & ~w_m[1:0]) | (w_d[1:0] & w_m[1:0]);
  wire [25:0] w_eent_new = (r_eentry & ~w_m[31:6]) | (w_d[31:6] & w_m[31:6]);
  wire [31:0] w_save_old = r_save[bus.csr_num[1:0]];

  // BADV is only captured for fetch address errors and misaligned accesses
  wire w_badv_pc = bus.wb_ex && (bus.wb_ecode == c_ECODE_ADE) && (bus.wb_esubcode == c_ESUB_ADEF);
  wire w_badv_va = bus.wb_ex && (bus.wb_ecode == c_ECODE_ALE);

  // CRMD: DA only by software; PLV/IE by exception > ertn > software
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_crmd <= c_CRMD_RST;
    end else begin
      if (w_we_crmd) r_crmd[3] <= w_crmd_new[3];
      if (bus.wb_ex)           r_crmd[2:0] <= 3'b000;
      else if (bus.ertn_flush) r_crmd[2:0] <= r_prmd;
      else if (w_we_crmd)      r_crmd[2:0] <= w_crmd_new[2:0];
    end
  end

  // PRMD saves the pre-exception PLV/IE; ECFG is software-only
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_prmd <= 3'b000;
      r_ecfg <= 13'h0;
    end else begin
      if (bus.wb_ex)      r_prmd <= r_crmd[2:0];
      else if (w_we_prmd) r_prmd <= w_prmd_new;
      if (w_we_ecfg) r_ecfg <= w_ecfg_new;
    end
  end

  // ESTAT: sample interrupt lines each cycle, record exception cause
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_is_sw    <= 2'b00;
      r_is_hw    <= 8'h00;
      r_is_ipi   <= 1'b0;
      r_ecode    <= 6'h0;
      r_esubcode <= 9'h0;
    end else begin
      r_is_hw  <= bus.hw_int_in;
      r_is_ipi <= bus.ipi_int_in;
      if (w_we_estat) r_is_sw <= w_sw_new;
      if (bus.wb_ex) begin
        r_ecode    <= bus.wb_ecode;
        r_esubcode <= bus.wb_esubcode;
      end
    end
  end

  // ERA/BADV capture the faulting PC/address on exception entry
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_era  <= 32'h0;
      r_badv <= 32'h0;
    end else begin
      if (bus.wb_ex)     r_era <= bus.wb_pc;
      else if (w_we_era) r_era <= (r_era & ~w_m) | (w_d & w_m);
      if (w_badv_pc)          r_badv <= bus.wb_pc;
      else if (w_badv_va)     r_badv <= bus.wb_vaddr;
      else if (bus.wb_ex)     r_badv <= r_badv;
      else if (w_we_badv)     r_badv <= (r_badv & ~w_m) | (w_d & w_m);
    end
  end

  // Software-only registers: EENTRY, SAVE0-3, TID
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_eentry <= 26'h0;
      r_tid    <= TID_INIT;
      for (int i = 0; i < 4; i++) r_save[i] <= 32'h0;
    end else begin
      if (w_we_eentry) r_eentry <= w_eent_new;
      if (w_we_tid)    r_tid <= (r_tid & ~w_m) | (w_d & w_m);
      if (w_we_save)   r_save[bus.csr_num[1:0]] <= (w_save_old & ~w_m) | (w_d & w_m);
    end
  end

`ifdef CSR_TIMER_EN
  logic [TIMER_W-1:0] r_tcfg;    // {InitVal, Periodic, En}
  logic [TIMER_W-1:0] r_tval;
  logic               r_ti;

  wire w_we_tcfg  = bus.csr_we && (bus.csr_num == c_ADDR_TCFG);
  wire w_we_ticlr = bus.csr_we && (bus.csr_num == 14'h044);
  wire [TIMER_W-1:0] w_tcfg_new = (r_tcfg & ~w_m[TIMER_W-1:0]) | (w_d[TIMER_W-1:0] & w_m[TIMER_W-1:0]);
  wire w_load   = w_we_tcfg && w_tcfg_new[0];
  // A fresh TCFG load preempts the expiry of the previous count
  wire w_expire = !w_load && r_tcfg[0] && (r_tval == TIMER_W'(1));

  // Timer: load on enable, count down, reload or stop on expiry
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_tcfg <= '0;
      r_tval <= '0;
    end else begin
      if (w_we_tcfg) r_tcfg <= w_tcfg_new;
      if (w_load)
        r_tval <= {w_tcfg_new[TIMER_W-1:2], 2'b00};
      else if (w_expire && r_tcfg[1])
        r_tval <= {r_tcfg[TIMER_W-1:2], 2'b00};
      else if (r_tcfg[0] && (r_tval != '0))
        r_tval <= r_tval - TIMER_W'(1);
    end
  end

  // Timer interrupt flag: expiry sets, TICLR clears, set wins
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                          r_ti <= 1'b0;
    else if (w_expire)                    r_ti <= 1'b1;
    else if (w_we_ticlr && w_d[0] && w_m[0]) r_ti <= 1'b0;
  end

  assign w_tcfg_v = r_tcfg;
  assign w_tval_v = r_tval;
  assign w_ti_v   = r_ti;
`else
  assign w_tcfg_v = '0;
  assign w_tval_v = '0;
  assign w_ti_v   = 1'b0;
`endif

  assign w_is    = {r_is_ipi, w_ti_v, 1'b0, r_is_hw, r_is_sw};
  assign w_estat = {1'b0, r_esubcode, r_ecode, 3'b000, w_is};

  // Read mux; unmapped addresses and TICLR read as zero
  always_comb begin
    w_rvalue = 32'h0;
    case (bus.csr_rnum)
      c_ADDR_CRMD:   w_rvalue = {28'h0, r_crmd};
      c_ADDR_PRMD:   w_rvalue = {29'h0, r_prmd};
      c_ADDR_ECFG:   w_rvalue = {19'h0, r_ecfg};
      c_ADDR_ESTAT:  w_rvalue = w_estat;
      c_ADDR_ERA:    w_rvalue = r_era;
      c_ADDR_BADV:   w_rvalue = r_badv;
      c_ADDR_EENTRY: w_rvalue = {r_eentry, 6'h00};
      14'h030:       w_rvalue = r_save[0];
      14'h031:       w_rvalue = r_save[1];
      14'h032:       w_rvalue = r_save[2];
      14'h033:       w_rvalue = r_save[3];
      c_ADDR_TID:    w_rvalue = r_tid;
      c_ADDR_TCFG:   w_rvalue = 32'(w_tcfg_v);
      c_ADDR_TVAL:   w_rvalue = 32'(w_tval_v);
      default:       w_rvalue = 32'h0;
    endcase
  end

  assign bus.csr_rvalue = w_rvalue;
  assign bus.has_int    = r_crmd[2] & (|(w_is & r_ecfg));
  assign bus.ex_entry   = {r_eentry, 6'h00};
  assign bus.era_pc     = r_era;
  assign bus.tid_rvalue = r_tid;

endmodule
`default_nettype wire

// File: tb/tb_csr_regfile.sv
`default_nettype none
// ============================================================================
//  Module      : tb_csr_regfile
//  Description : Scoreboard bench for csr_regfile. Stimulus pushes expected
//                values; a negedge monitor pops and compares.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_csr_regfile;

  localparam logic [31:0] c_TID_INIT = 32'h5A5A_0001;
  localparam int S_RD = 0, S_HI = 1, S_EE = 2, S_ERA = 3, S_TID = 4;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic chk_valid = 1'b0;

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0] q_exp [$];
  int          q_sel [$];
  string       q_name[$];

  logic [31:0] m_exp, m_act;
  int          m_sel;
  string       m_name;

  csr_regfile_if bus ();

  csr_regfile #(.TIMER_W(32), .TID_INIT(c_TID_INIT)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // Monitor: compare the DUT output against the oldest expectation
  always @(negedge clk) begin
    if (chk_valid) begin
      n_chk++;
      if (q_exp.size() == 0) begin
        n_fail++;
        $display("FAIL scoreboard_empty: got a probe with no expected value");
      end else begin
        m_exp  = q_exp.pop_front();
        m_sel  = q_sel.pop_front();
        m_name = q_name.pop_front();
        case (m_sel)
          S_HI:    m_act = {31'h0, bus.has_int};
          S_EE:    m_act = bus.ex_entry;
          S_ERA:   m_act = bus.era_pc;
          S_TID:   m_act = bus.tid_rvalue;
          default: m_act = bus.csr_rvalue;
        endcase
        if (m_act !== m_exp) begin
          n_fail++;
          $display("FAIL %s: got 0x%08h expected 0x%08h", m_name, m_act, m_exp);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input int sel, input logic [13:0] num, input logic [31:0] exp, input string name);
    bus.csr_rnum = num;
    q_exp.push_back(exp);
    q_sel.push_back(sel);
    q_name.push_back(name);
    chk_valid = 1'b1;
    @(negedge clk); #1;
    chk_valid = 1'b0;
  endtask

  task automatic wr(input logic [13:0] num, input logic [31:0] d, input logic [31:0] m);
    bus.csr_we = 1'b1; bus.csr_num = num; bus.csr_wdata = d; bus.csr_wmask = m;
    tick();
    bus.csr_we = 1'b0;
  endtask

  task automatic set_ex(input logic [5:0] ec, input logic [8:0] sub, input logic [31:0] pc, input logic [31:0] va);
    bus.wb_ex = 1'b1; bus.wb_ecode = ec; bus.wb_esubcode = sub; bus.wb_pc = pc; bus.wb_vaddr = va;
  endtask

  task automatic ex(input logic [5:0] ec, input logic [8:0] sub, input logic [31:0] pc, input logic [31:0] va);
    set_ex(ec, sub, pc, va);
    tick();
    bus.wb_ex = 1'b0;
  endtask

  initial begin
    bus.csr_rnum = '0; bus.csr_we = 1'b0; bus.csr_num = '0; bus.csr_wmask = '0; bus.csr_wdata = '0;
    bus.wb_ex = 1'b0; bus.wb_ecode = '0; bus.wb_esubcode = '0; bus.wb_pc = '0; bus.wb_vaddr = '0;
    bus.ertn_flush = 1'b0; bus.hw_int_in = '0; bus.ipi_int_in = 1'b0;

    // Reset values
    tick(); tick();
    chk(S_RD,  14'h000, 32'h8,        "rst_crmd");
    chk(S_TID, 14'h000, c_TID_INIT,   "rst_tid");
    chk(S_HI,  14'h000, 32'h0,        "rst_has_int");
    chk(S_EE,  14'h000, 32'h0,        "rst_ex_entry");
    chk(S_ERA, 14'h000, 32'h0,        "rst_era_pc");
    chk(S_RD,  14'h005, 32'h0,        "rst_estat");
    resetn = 1'b1;
    tick();

    // Masked write with same-cycle read of the old value
    bus.csr_we = 1'b1; bus.csr_num = 14'h000; bus.csr_wdata = 32'h7; bus.csr_wmask = 32'h4;
    chk(S_RD, 14'h000, 32'h8, "crmd_same_cycle_old");
    tick();
    bus.csr_we = 1'b0;
    chk(S_RD, 14'h000, 32'hC, "crmd_masked");

    // ALE exception then ertn
    wr(14'h000, 32'h7, 32'h7);
    chk(S_RD, 14'h000, 32'hF, "crmd_setup");
    ex(6'h09, 9'h0, 32'h1C00_0100, 32'h0000_1003);
    chk(S_RD,  14'h006, 32'h1C00_0100, "ale_era");
    chk(S_ERA, 14'h000, 32'h1C00_0100, "ale_era_pc");
    chk(S_RD,  14'h007, 32'h0000_1003, "ale_badv");
    chk(S_RD,  14'h001, 32'h7,         "ale_prmd");
    chk(S_RD,  14'h000, 32'h8,         "ale_crmd");
    chk(S_RD,  14'h005, 32'h0009_0000, "ale_estat");
    bus.ertn_flush = 1'b1; tick(); bus.ertn_flush = 1'b0;
    chk(S_RD,  14'h000, 32'hF,         "ertn_crmd");

    // ADEF captures PC, ADEM leaves BADV alone
    ex(6'h08, 9'h000, 32'h1C00_0200, 32'h0000_DEAD);
    chk(S_RD, 14'h007, 32'h1C00_0200, "adef_badv");
    chk(S_RD, 14'h005, 32'h0008_0000, "adef_estat");
    ex(6'h08, 9'h001, 32'h1C00_0300, 32'h0000_BEEF);
    chk(S_RD, 14'h007, 32'h1C00_0200, "adem_badv_hold");
    chk(S_RD, 14'h005, 32'h0048_0000, "adem_estat");
    chk(S_RD, 14'h001, 32'h0,         "adem_prmd");
    chk(S_ERA, 14'h000, 32'h1C00_0300, "adem_era_pc");

    // Exception beats a same-cycle CRMD write
    wr(14'h000, 32'h7, 32'h7);
    bus.csr_we = 1'b1; bus.csr_num = 14'h000; bus.csr_wdata = 32'h7; bus.csr_wmask = 32'h7;
    set_ex(6'h01, 9'h0, 32'h1C00_0400, 32'h0);
    tick();
    bus.csr_we = 1'b0; bus.wb_ex = 1'b0;
    chk(S_RD, 14'h000, 32'h8, "ex_over_we_crmd");
    chk(S_RD, 14'h001, 32'h7, "ex_over_we_prmd");

    // Exception beats a same-cycle ertn
    set_ex(6'h02, 9'h0, 32'h1C00_0500, 32'h0);
    bus.ertn_flush = 1'b1;
    tick();
    bus.wb_ex = 1'b0; bus.ertn_flush = 1'b0;
    chk(S_RD, 14'h000, 32'h8, "ex_over_ertn_crmd");
    chk(S_RD, 14'h001, 32'h0, "ex_over_ertn_prmd");

    // Field restrictions and plain registers
    wr(14'h001, 32'hFF, 32'hFF);
    chk(S_RD, 14'h001, 32'h7, "prmd_fields");
    wr(14'h030, 32'hA5A5_A5A5, 32'hFFFF_FFFF);
    wr(14'h033, 32'h0F0F_0F0F, 32'h0000_FFFF);
    chk(S_RD, 14'h030, 32'hA5A5_A5A5, "save0");
    chk(S_RD, 14'h033, 32'h0000_0F0F, "save3_masked");
    wr(14'h00C, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk(S_EE, 14'h000, 32'hFFFF_FFC0, "eentry_ex_entry");
    chk(S_RD, 14'h00C, 32'hFFFF_FFC0, "eentry_read");
    wr(14'h040, 32'h1234_5678, 32'hFFFF_0000);
    chk(S_TID, 14'h000, 32'h1234_0001, "tid_masked");
    wr(14'h002, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk(S_RD, 14'h002, 32'h0, "unmapped_read");
    wr(14'h004, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk(S_RD, 14'h004, 32'h1BFF, "ecfg_fields");
    wr(14'h004, 32'h0, 32'hFFFF_FFFF);
    wr(14'h005, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk(S_RD, 14'h005, 32'h0002_0003, "estat_sw_fields");
    wr(14'h005, 32'h0, 32'h3);

    // Hardware interrupt with one-cycle sample latency
    wr(14'h004, 32'h4, 32'h1FFF);
    wr(14'h000, 32'h4, 32'h4);
    bus.hw_int_in = 8'h01;
    chk(S_HI, 14'h000, 32'h0, "hw_int_latency");
    tick();
    chk(S_HI, 14'h000, 32'h1, "hw_int");
    chk(S_RD, 14'h005, 32'h0002_0004, "hw_int_estat");
    wr(14'h004, 32'h0, 32'h1FFF);
    chk(S_HI, 14'h000, 32'h0, "hw_int_lie_off");
    bus.hw_int_in = 8'h00;

    // IPI, then gated by CRMD.IE
    wr(14'h004, 32'h1000, 32'h1FFF);
    bus.ipi_int_in = 1'b1;
    tick();
    chk(S_HI, 14'h000, 32'h1, "ipi_int");
    wr(14'h000, 32'h0, 32'h4);
    chk(S_HI, 14'h000, 32'h0, "ie_gate");
    bus.ipi_int_in = 1'b0;
    wr(14'h004, 32'h0, 32'h1FFF);

    // Timer
    wr(14'h004, 32'h800, 32'h1FFF);
    wr(14'h000, 32'h4, 32'h4);
`ifdef CSR_TIMER_EN
    wr(14'h041, 32'h13, 32'hFFFF_FFFF);
    chk(S_RD, 14'h042, 32'd16, "tval_load");
    for (int k = 15; k >= 2; k--) begin
      tick();
      chk(S_RD, 14'h042, k, "tval_count");
    end
    tick();
    chk(S_HI, 14'h000, 32'h0, "timer_not_yet");
    tick();
    chk(S_HI, 14'h000, 32'h1, "timer_fire");
    tick();
    chk(S_RD, 14'h042, 32'd15, "tval_periodic_reload");
    tick();
    chk(S_RD, 14'h005, 32'h0002_0800, "timer_estat");
    wr(14'h044, 32'h1, 32'h1);
    chk(S_HI, 14'h000, 32'h0, "ticlr_clear");
    chk(S_RD, 14'h044, 32'h0, "ticlr_read");
    chk(S_RD, 14'h041, 32'h13, "tcfg_read");
    wr(14'h041, 32'h9, 32'hFFFF_FFFF);
    repeat (12) tick();
    chk(S_RD, 14'h042, 32'h0, "tval_oneshot_stop");
    chk(S_HI, 14'h000, 32'h1, "timer_oneshot_fire");
    wr(14'h044, 32'h1, 32'h1);
    chk(S_HI, 14'h000, 32'h0, "ticlr_oneshot");
`else
    wr(14'h041, 32'h13, 32'hFFFF_FFFF);
    repeat (20) tick();
    chk(S_RD, 14'h041, 32'h0, "tcfg_absent");
    chk(S_RD, 14'h042, 32'h0, "tval_absent");
    chk(S_HI, 14'h000, 32'h0, "timer_int_absent");
`endif

    // Asynchronous reset between clock edges
    @(posedge clk); #2;
    resetn = 1'b0;
    chk(S_RD,  14'h000, 32'h8,      "midrst_crmd");
    chk(S_TID, 14'h000, c_TID_INIT, "midrst_tid");
    chk(S_RD,  14'h030, 32'h0,      "midrst_save0");
    chk(S_ERA, 14'h000, 32'h0,      "midrst_era_pc");
    chk(S_HI,  14'h000, 32'h0,      "midrst_has_int");
    resetn = 1'b1;
    tick();
    chk(S_RD,  14'h000, 32'h8,      "post_rst_crmd");

    for (int i = 0; i < 10 && q_exp.size() != 0; i++) @(negedge clk);
    if (q_exp.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d left expected 0", q_exp.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire
